// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot decoder with enable, direct-load and auto-scan modes.
// Define DECODER_N_TO_2N_SEQ_ACTIVE_LOW_EN to make Y active-low (idx and wrap unaffected).
module decoder_n_to_2n_seq #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                E,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        A,
  input  logic [DW-1:0]       dwell,
  output logic [(1<<N)-1:0]   Y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int unsigned L = 1 << N;

`ifdef DECODER_N_TO_2N_SEQ_ACTIVE_LOW_EN
  localparam logic [L-1:0] Y_OFF = '1;
`else
  localparam logic [L-1:0] Y_OFF = '0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic [L-1:0]   y_q, y_d;
  logic           wrap_q, wrap_d;
  logic [N-1:0]   idx_inc;

  // Polarity is folded in here so Y leaves straight from a flop.
  function automatic logic [L-1:0] line_sel(input logic [N-1:0] i);
    logic [L-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh ^ Y_OFF;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    y_d     = y_q;
    wrap_d  = 1'b0;
    if (!E) begin
      state_d = IDLE;
      y_d     = Y_OFF;
      dcnt_d  = '0;
    end else if (!mode) begin
      state_d = DIRECT;
      idx_d   = load ? A : idx_q;
      y_d     = line_sel(idx_d);
      dcnt_d  = '0;
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      y_d     = line_sel(idx_q);
      dcnt_d  = '0;
    end else if (dcnt_q >= dwell) begin
      dcnt_d  = '0;
      idx_d   = idx_inc;
      y_d     = line_sel(idx_inc);
      wrap_d  = &idx_q;
    end else begin
      dcnt_d  = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      y_q     <= Y_OFF;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Bench for decoder_n_to_2n_seq (N=2, DW=8, active-high build): directed vectors
// with literal expectations plus a per-cycle comparison against a behavioural model.
module tb_decoder_n_to_2n_seq;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int L  = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          E = 1'b0, mode = 1'b0, load = 1'b0;
  logic [N-1:0]  A = '0;
  logic [DW-1:0] dwell = '0;
  logic [L-1:0]  Y;
  logic [N-1:0]  idx;
  logic          wrap;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Model: which line is lit, whether lines are on, and how many cycles the
  // current line has been shown while scanning.
  int m_idx  = 0;
  bit m_on   = 1'b0;
  bit m_scan = 1'b0;
  int m_held = 0;
  bit m_wrap = 1'b0;

  decoder_n_to_2n_seq #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .load(load),
    .A(A), .dwell(dwell), .Y(Y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = 0; m_on = 1'b0; m_scan = 1'b0; m_held = 0; m_wrap = 1'b0;
    end else if (!E) begin
      m_on = 1'b0; m_scan = 1'b0; m_held = 0; m_wrap = 1'b0;
    end else if (!mode) begin
      if (load) m_idx = int'(A);
      m_on = 1'b1; m_scan = 1'b0; m_wrap = 1'b0;
    end else if (!m_scan) begin
      m_scan = 1'b1; m_on = 1'b1; m_held = 1; m_wrap = 1'b0;
    end else if (m_held > int'(dwell)) begin
      m_wrap = (m_idx == L - 1);
      m_idx  = (m_idx + 1) % L;
      m_held = 1;
    end else begin
      m_held++;
      m_wrap = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_Y", 32'(Y), m_on ? 32'(1 << m_idx) : 32'd0);
      check("cyc_idx", 32'(idx), 32'(m_idx));
      check("cyc_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] seq_y [5];
  bit         seq_w [5];
  int         wraps;

  initial begin
    seq_y = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    seq_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #1;
    check("rst_Y", 32'(Y), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    step(3);
    check("idle_Y", 32'(Y), 32'd0);
    check("idle_idx", 32'(idx), 32'd0);

    E = 1'b1; mode = 1'b0; A = 2'b10; load = 1'b1;
    step(1);
    check("load_Y", 32'(Y), 32'b0100);
    check("load_idx", 32'(idx), 32'd2);
    load = 1'b0; A = 2'b01;
    step(4);
    check("noload_Y", 32'(Y), 32'b0100);
    check("noload_idx", 32'(idx), 32'd2);

    mode = 1'b1; dwell = 8'd0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("scan0_Y", 32'(Y), 32'(seq_y[i]));
      check("scan0_wrap", 32'(wrap), 32'(seq_w[i]));
    end

    mode = 1'b0; A = 2'b00; load = 1'b1;
    step(1);
    load = 1'b0; mode = 1'b1; dwell = 8'd2;
    step(1);
    check("scan2_entry_Y", 32'(Y), 32'b0001);
    wraps = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (wrap) wraps++;
    end
    check("scan2_wraps", 32'(wraps), 32'd2);
    step(1);
    check("scan2_hold_Y", 32'(Y), 32'b0001);
    dwell = 8'd0;
    step(1);
    check("dwell_lower_Y", 32'(Y), 32'b0010);

    for (int k = 0; k < 8 && idx != 2'd3; k++) step(1);
    check("reach_idx3", 32'(idx), 32'd3);
    E = 1'b0;
    step(1);
    check("edrop_Y", 32'(Y), 32'd0);
    check("edrop_idx", 32'(idx), 32'd3);
    step(2);
    check("edrop_hold_idx", 32'(idx), 32'd3);
    E = 1'b1; dwell = 8'd2;
    step(1);
    check("erise_Y", 32'(Y), 32'b1000);
    step(2);
    check("erise_hold_Y", 32'(Y), 32'b1000);
    step(1);
    check("erise_step_Y", 32'(Y), 32'b0001);
    check("erise_wrap", 32'(wrap), 32'd1);

    step(4);
    check("pre_rst_idx", 32'(idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_Y", 32'(Y), 32'd0);
    check("async_rst_idx", 32'(idx), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("post_rst_Y", 32'(Y), 32'b0001);

    mode = 1'b0; load = 1'b1;
    for (int a = 0; a < L; a++) begin
      A = 2'(a);
      step(1);
      check("dir_Y", 32'(Y), 32'(1 << a));
    end
    E = 1'b0; A = 2'b00;
    step(1);
    check("e0_load_Y", 32'(Y), 32'd0);
    check("e0_load_idx", 32'(idx), 32'd3);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
